fmc_i2c_cfg_sequencer: RTL



---
 rtl/fmc_i2c_pkg.sv | 35 +++
 rtl/fmc_i2c_cfg_rom.sv | 21 ++
 rtl/fmc_i2c_cfg_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fmc_i2c_pkg.sv
// Shared types and constants for the FMC424 I2C configuration sequencer.
// Byte-engine op codes, table entry layout and sequencer states.
package fmc_i2c_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_STOP  = 2'd2
  } op_e;

  typedef struct packed {
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam logic [6:0] CPLD_ADDR     = 7'h3E;
  localparam logic [6:0] SI5338_ADDR   = 7'h70;
  localparam logic [7:0] CPLD_CTRL_REG = 8'h02;
  localparam logic [7:0] CPLD_LED4_ON  = 8'h01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE_START,
    S_ISSUE_ADDR,
    S_ISSUE_REG,
    S_ISSUE_DATA,
    S_ISSUE_STOP,
    S_WAIT_RSP,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/fmc_i2c_cfg_rom.sv
// Fixed configuration table: CPLD control/LED and SI5338 setup writes.
// Pure combinational lookup from entry index to register write.
module fmc_i2c_cfg_rom
  import fmc_i2c_pkg::*;
(
  input  logic [3:0] idx_i,
  output cfg_entry_t entry_o
);

  always_comb begin
    entry_o = '0;
    case (idx_i)
      4'd0: entry_o = '{CPLD_ADDR, CPLD_CTRL_REG, CPLD_LED4_ON};
      4'd1: entry_o = '{SI5338_ADDR, 8'hE6, 8'h10};
      4'd2: entry_o = '{SI5338_ADDR, 8'hF1, 8'hE5};
      4'd3: entry_o = '{CPLD_ADDR, CPLD_CTRL_REG, 8'h00};
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/fmc_i2c_cfg_sequencer.sv
// Walks the config table and issues START/addr/reg/data/STOP byte ops,
// retrying NACKed entries after a bus-free gap and flagging exhaustion.
module fmc_i2c_cfg_sequencer
  import fmc_i2c_pkg::*;
#(
  parameter int NUM_CMDS   = 4,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] fail_index,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_ack
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0] IDX_LAST = 4'(NUM_CMDS - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_e state_q, state_d;
  state_e pend_q, pend_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] retry_q, retry_d;
  logic nack_q, nack_d;
  logic [GW-1:0] gap_q, gap_d;
  logic error_q, error_d;
  logic [3:0] fidx_q, fidx_d;
  cfg_entry_t entry;

  fmc_i2c_cfg_rom u_rom (
    .idx_i  (idx_q),
    .entry_o(entry)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      nack_q  <= 1'b0;
      gap_q   <= '0;
      error_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      nack_q  <= nack_d;
      gap_q   <= gap_d;
      error_q <= error_d;
      fidx_q  <= fidx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    nack_d    = nack_q;
    gap_d     = gap_q;
    error_d   = error_q;
    fidx_d    = fidx_q;
    cmd_valid = 1'b0;
    cmd_op    = OP_START;
    cmd_data  = 8'h00;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE_START;
          idx_d   = '0;
          retry_d = '0;
          nack_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_ISSUE_START: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
      end
      S_ISSUE_ADDR: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = {entry.dev_addr, 1'b0};
      end
      S_ISSUE_REG: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = entry.reg_addr;
      end
      S_ISSUE_DATA: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = entry.data;
      end
      S_ISSUE_STOP: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          case (pend_q)
            S_ISSUE_START: state_d = S_ISSUE_ADDR;
            S_ISSUE_ADDR: begin
              nack_d  = ~rsp_ack;
              state_d = rsp_ack ? S_ISSUE_REG : S_ISSUE_STOP;
            end
            S_ISSUE_REG: begin
              nack_d  = ~rsp_ack;
              state_d = rsp_ack ? S_ISSUE_DATA : S_ISSUE_STOP;
            end
            S_ISSUE_DATA: begin
              nack_d  = ~rsp_ack;
              state_d = S_ISSUE_STOP;
            end
            S_ISSUE_STOP: begin
              gap_d   = '0;
              state_d = S_GAP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d  = '0;
          nack_d = 1'b0;
          if (nack_q && (retry_q < RETRY_MAX)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE_START;
          end else if (nack_q) begin
            error_d = 1'b1;
            fidx_d  = idx_q;
            state_d = S_ERROR;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            retry_d = '0;
            state_d = S_ISSUE_START;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The issue state itself is remembered so WAIT_RSP knows what completed.
    if (cmd_valid && cmd_ready) begin
      pend_d  = state_q;
      state_d = S_WAIT_RSP;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE) &&
                (state_q != S_ERROR);
  assign error      = error_q;
  assign fail_index = fidx_q;

  always_ff @(posedge CLK) begin
    if (!reset && rsp_valid) begin
      assert (state_q == S_WAIT_RSP)
        else $error("rsp_valid outside WAIT_RSP");
    end
  end

endmodule
